// File: rtl/divu_pkg.sv
// Shared types and constants for the sequential unsigned divider.
package divu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int N_WIDTH_DEF = 4;
   localparam int D_WIDTH_DEF = 2;
   localparam int CNT_W_DEF   = $clog2(N_WIDTH_DEF + 1);

   // Iteration counter must hold 0..N_WIDTH.
   function automatic int divu_cnt_w(input int n_width);
      return $clog2(n_width + 1);
   endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract d.
// Purely combinational; no flow control.
module divu_step #(
   parameter int D_WIDTH = 2
) (
   input  logic [D_WIDTH-1:0] rem_i,
   input  logic               bit_i,
   input  logic [D_WIDTH-1:0] d_i,
   output logic [D_WIDTH-1:0] rem_o,
   output logic               q_bit_o
);

   logic [D_WIDTH:0] shifted;
   logic [D_WIDTH:0] trial;

   always_comb begin
      shifted = {rem_i, bit_i};
      trial   = shifted - {1'b0, d_i};
      // A non-negative trial means the divisor fits; rem stays below d so trial fits D_WIDTH bits.
      q_bit_o = (shifted >= {1'b0, d_i});
      rem_o   = q_bit_o ? trial[D_WIDTH-1:0] : shifted[D_WIDTH-1:0];
   end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned divider, one quotient bit per clock; latency N_WIDTH+1 (1 for d=0 with DIVU_DIVZERO_EN).
// No backpressure: start is accepted only when busy=0, otherwise dropped.
module divu_seq
   import divu_pkg::*;
#(
   parameter int N_WIDTH = N_WIDTH_DEF,
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_WIDTH-1:0] n,
   input  logic [D_WIDTH-1:0] d,
   output logic               busy,
   output logic               done,
   output logic [N_WIDTH-1:0] q,
   output logic [D_WIDTH-1:0] r
`ifdef DIVU_DIVZERO_EN
   , output logic             dz
`endif
);

   localparam int CW = divu_cnt_w(N_WIDTH);

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [N_WIDTH-1:0] nq_q, nq_d;
   logic [D_WIDTH-1:0] d_q, d_d;
   logic [D_WIDTH-1:0] rem_q, rem_d;
   logic [N_WIDTH-1:0] q_q, q_d;
   logic [D_WIDTH-1:0] r_q, r_d;
`ifdef DIVU_DIVZERO_EN
   logic               dz_q, dz_d;
`endif

   logic               accept;
   logic               last_iter;
   logic               dz_start;
   logic [D_WIDTH-1:0] step_rem;
   logic               step_qb;

`ifdef DIVU_DIVZERO_EN
   assign dz_start = (d == '0);
`else
   assign dz_start = 1'b0;
`endif

   assign accept    = start && (state_q != ST_RUN);
   assign last_iter = (state_q == ST_RUN) && (cnt_q == CW'(N_WIDTH - 1));

   divu_step #(.D_WIDTH(D_WIDTH)) u_step (
      .rem_i   (rem_q),
      .bit_i   (nq_q[N_WIDTH-1]),
      .d_i     (d_q),
      .rem_o   (step_rem),
      .q_bit_o (step_qb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         nq_q    <= '0;
         d_q     <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
`ifdef DIVU_DIVZERO_EN
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nq_q    <= nq_d;
         d_q     <= d_d;
         rem_q   <= rem_d;
         q_q     <= q_d;
         r_q     <= r_d;
`ifdef DIVU_DIVZERO_EN
         dz_q    <= dz_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) state_d = dz_start ? ST_DONE : ST_RUN;
            else       state_d = ST_IDLE;
         end
         ST_RUN:  if (last_iter) state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Dividend register doubles as the quotient accumulator: MSB out, quotient bit in at LSB.
   always_comb begin
      cnt_d = cnt_q;
      nq_d  = nq_q;
      d_d   = d_q;
      rem_d = rem_q;
      q_d   = q_q;
      r_d   = r_q;
`ifdef DIVU_DIVZERO_EN
      dz_d  = dz_q;
`endif
      if (accept) begin
         nq_d  = n;
         d_d   = d;
         rem_d = '0;
         cnt_d = '0;
         if (dz_start) begin
            q_d  = '1;
            r_d  = n[D_WIDTH-1:0];
`ifdef DIVU_DIVZERO_EN
            dz_d = 1'b1;
`endif
         end
      end else if (state_q == ST_RUN) begin
         nq_d  = {nq_q[N_WIDTH-2:0], step_qb};
         rem_d = step_rem;
         cnt_d = cnt_q + CW'(1);
         if (last_iter) begin
            q_d  = {nq_q[N_WIDTH-2:0], step_qb};
            r_d  = step_rem;
`ifdef DIVU_DIVZERO_EN
            dz_d = 1'b0;
`endif
         end
      end
   end

   always_comb begin
      busy = (state_q == ST_RUN);
      done = (state_q == ST_DONE);
      q    = q_q;
      r    = r_q;
`ifdef DIVU_DIVZERO_EN
      dz   = dz_q;
`endif
   end

endmodule

// File: doc/divu_seq.md
# divu_seq

Sequential unsigned divider and the inverse companion to the team's combinational unsigned multipliers. It accepts an N_WIDTH-bit dividend and a D_WIDTH-bit divisor on a start strobe and runs a restoring shift/subtract loop that retires one quotient bit per clock. It returns a registered quotient and remainder with a one-cycle done pulse. It sits beside the multiplier as the arithmetic core's division path.

## Interface
- N_WIDTH, 4, dividend and quotient width (≥ 2)
- D_WIDTH, 2, divisor and remainder width (1..N_WIDTH)
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high; dominates all other inputs
- start  in  1  request; sampled only when busy=0
- n  in  N_WIDTH  dividend; sampled with accepted start
- d  in  D_WIDTH  divisor; sampled with accepted start
- busy  out  1  division in progress
- done  out  1  one-cycle pulse; q, r (and dz) valid in this cycle
- q  out  N_WIDTH  quotient; held until next completion
- r  out  D_WIDTH  remainder; held until next completion
- dz  out  1  divide-by-zero flag (present only with DIVU_DIVZERO_EN)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0. On start=1, latch n and d, clear the partial remainder rem (D_WIDTH bits) and the iteration counter, then go to RUN.
- RUN: busy=1. Each cycle:
  - shifted = {rem, next dividend MSB} (D_WIDTH+1 bits); trial = shifted − {0,d}.
  - trial ≥ 0 → rem = trial[D_WIDTH-1:0], quotient bit = 1.
  - Otherwise → rem = shifted[D_WIDTH-1:0], quotient bit = 0.
  - After exactly N_WIDTH iterations, load the q and r output registers and go to DONE.
- DONE: done=1, busy=0, lasts one cycle. Next state is RUN if start=1 (back-to-back accepted, with new n/d latched), otherwise IDLE.
- q and r change only on the DONE-entry edge. During RUN they hold the previous result.
- start while busy=1 is ignored and never queued.
- Divisor zero without the macro: the algorithm runs unmodified, giving q = all-ones and r = n[D_WIDTH-1:0].
- Invariant for d≠0: n = q·d + r with r < d.

## Timing
- Reset values: state IDLE, busy=0, done=0, q=0, r=0, dz=0.
- An accepted start on edge E0 sets busy=1 in cycle 1. Iterations occur on edges E1..EN (N = N_WIDTH). done=1 and busy=0 in cycle N_WIDTH+1.
- Latency from the start cycle to the done cycle is N_WIDTH+1, i.e. 5 for the defaults. Throughput is one result per N_WIDTH+1 cycles with back-to-back starts.
- rst during RUN aborts: no done pulse, q/r forced to 0, IDLE on the next cycle.
- rst and start in the same cycle: rst wins and start is dropped.

## Configuration
- DIVU_DIVZERO_EN, when defined:
  - The dz port exists.
  - An accepted start with d=0 goes IDLE→DONE directly, so done arrives in cycle 1 (latency 1), with q = all-ones, r = n[D_WIDTH-1:0] and dz=1.
  - dz is otherwise 0 and is updated with q/r at each completion.
- When undefined: no dz port, and d=0 takes the full N_WIDTH+1 cycles with the algorithmic result above.

## Structure
- The shared package/header (alongside global.vh) holds:
  - the state encodings (IDLE=0, RUN=1, DONE=2, 2-bit);
  - the default width constants;
  - the counter width, clog2(N_WIDTH+1).
- Natural sub-module: divu_step, a combinational single iteration. It takes rem, the incoming bit and d, and returns the new rem and the quotient bit. The top module holds the FSM, counter, dividend shift register and output registers.

## Test plan
- n=13, d=3, start pulse in cycle 0 → done=1 in cycle 5 only, q=4, r=1; busy high in cycles 1–4.
- n=15, d=1 → q=15, r=0. n=2, d=3 → q=0, r=2. Also an exhaustive sweep of all n in 0..15 and d in 1..3 checking n = q·d + r with r < d.
- n=9, d=0:
  - without the macro → done in cycle 5, q=15, r=1;
  - with DIVU_DIVZERO_EN → done in cycle 1, q=15, r=1, dz=1. A following 6/2 → q=3, r=0, dz=0.
- start re-asserted in cycles 2–4 with different operands → ignored; the original result is returned.
- start held high during the done cycle with n=7, d=2 → the first result completes, then q=3, r=1 arrives 5 cycles later. q/r hold the old values until then.
- rst asserted in cycle 3 of a run → no done pulse, q=r=0, busy=0; a fresh start afterwards completes normally.
